// File: rtl/mux_scan_nto1.sv
// rtl/mux_scan_nto1.sv - registered N:1 mux with auto channel-scan engine.
// Define MUX_SCAN_CONT_EN for continuous scanning; default is a single-shot sweep.
module mux_scan_nto1 #(
  parameter int NCH   = 16,
  parameter int SELW  = 4,
  parameter int WIDTH = 1,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] inp,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel_in,
  input  logic                 start,
  output logic [WIDTH-1:0]     outp,
  output logic [SELW-1:0]      sel_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  localparam int DW = $clog2(DWELL) + 1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  localparam logic [DW-1:0]   LAST_DW = DW'(DWELL - 1);
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [WIDTH-1:0]  outp_q, outp_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  man_data;
  logic [WIDTH-1:0]  scan_data;
  logic              sel_in_ok;

  assign sel_in_ok = ({1'b0, sel_in} < NCH_W);

  always_comb begin
    man_data  = '0;
    scan_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_in == SELW'(k)) man_data  = inp[k*WIDTH +: WIDTH];
      if (ch_q   == SELW'(k)) scan_data = inp[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    outp_d  = outp_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (!mode) begin
      // Manual select; also aborts any sweep in progress without a done pulse.
      state_d = IDLE;
      ch_d    = '0;
      dwell_d = '0;
      sel_d   = sel_in;
      if (sel_in_ok) begin
        outp_d  = man_data;
        valid_d = 1'b1;
      end else begin
        outp_d  = '0;
      end
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = SCAN;
        ch_d    = '0;
        dwell_d = '0;
      end
    end else begin
      outp_d  = scan_data;
      sel_d   = ch_q;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      if (dwell_q == LAST_DW) begin
        dwell_d = '0;
        if (ch_q == LAST_CH) begin
          done_d = 1'b1;
          ch_d   = '0;
`ifdef MUX_SCAN_CONT_EN
          state_d = SCAN;
`else
          state_d = IDLE;
`endif
        end else begin
          ch_d = ch_q + SELW'(1);
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      dwell_q <= '0;
      outp_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      outp_q  <= outp_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // busy tracks the cycles carrying scan samples, so it drops on the abort edge.
  assign outp    = outp_q;
  assign sel_out = sel_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb/tb_mux_scan_nto1.sv - directed table-driven bench for mux_scan_nto1.
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [15:0] a_inp;
  logic        a_mode, a_start;
  logic [3:0]  a_sel;
  logic        a_outp;
  logic [3:0]  a_sel_out;
  logic        a_valid, a_busy, a_done;

  logic [31:0] b_inp;
  logic        b_mode, b_start;
  logic [1:0]  b_sel;
  logic [7:0]  b_outp;
  logic [1:0]  b_sel_out;
  logic        b_valid, b_busy, b_done;

  logic [9:0]  c_inp;
  logic        c_mode, c_start;
  logic [3:0]  c_sel;
  logic        c_outp;
  logic [3:0]  c_sel_out;
  logic        c_valid, c_busy, c_done;

  mux_scan_nto1 u_a (
    .clk(clk), .rst_n(rst_n), .inp(a_inp), .mode(a_mode), .sel_in(a_sel), .start(a_start),
    .outp(a_outp), .sel_out(a_sel_out), .valid(a_valid), .busy(a_busy), .done(a_done)
  );

  mux_scan_nto1 #(.NCH(4), .SELW(2), .WIDTH(8), .DWELL(3)) u_b (
    .clk(clk), .rst_n(rst_n), .inp(b_inp), .mode(b_mode), .sel_in(b_sel), .start(b_start),
    .outp(b_outp), .sel_out(b_sel_out), .valid(b_valid), .busy(b_busy), .done(b_done)
  );

  mux_scan_nto1 #(.NCH(10), .SELW(4), .WIDTH(1), .DWELL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .inp(c_inp), .mode(c_mode), .sel_in(c_sel), .start(c_start),
    .outp(c_outp), .sel_out(c_sel_out), .valid(c_valid), .busy(c_busy), .done(c_done)
  );

  typedef struct {
    logic [3:0] sel;
    logic       exp_out;
  } man_vec_t;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    man_vec_t   mv[16];
    logic       exp_bits[16];
    logic [7:0] bexp[4];
    int         n_sw;

    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      mv[i].sel     = 4'(i);
      mv[i].exp_out = exp_bits[i];
    end
    bexp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    a_inp = 16'h05FA; a_mode = 1'b0; a_start = 1'b0; a_sel = 4'd3;
    b_inp = 32'hDDCCBBAA; b_mode = 1'b0; b_start = 1'b0; b_sel = 2'd0;
    c_inp = 10'h3FF; c_mode = 1'b0; c_start = 1'b0; c_sel = 4'd0;

    #12;
    chk("reset_a", 32'({a_outp, a_sel_out, a_valid, a_busy, a_done}), 32'd0);
    chk("reset_b", 32'({b_outp, b_sel_out, b_valid, b_busy, b_done}), 32'd0);
    rst_n = 1'b1;

    // manual select table
    for (int i = 0; i < 16; i++) begin
      a_sel = mv[i].sel;
      tick();
      chk("man_outp", 32'(a_outp), 32'(mv[i].exp_out));
      chk("man_valid", 32'(a_valid), 32'd1);
      chk("man_sel_out", 32'(a_sel_out), 32'(mv[i].sel));
    end

    // auto sweep on defaults; start pulse mid-sweep must be ignored
    a_mode = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("sweep_gap_valid", 32'(a_valid), 32'd0);
`ifdef MUX_SCAN_CONT_EN
    n_sw = 40;
`else
    n_sw = 16;
`endif
    for (int i = 0; i < n_sw; i++) begin
      a_start = (i == 7);
      tick();
      chk("sweep_sel_out", 32'(a_sel_out), 32'(i % 16));
      chk("sweep_outp", 32'(a_outp), 32'(exp_bits[i % 16]));
      chk("sweep_valid", 32'(a_valid), 32'd1);
      chk("sweep_busy", 32'(a_busy), 32'd1);
      chk("sweep_done", 32'(a_done), 32'((i % 16) == 15));
    end
    a_start = 1'b0;
`ifndef MUX_SCAN_CONT_EN
    tick();
    chk("sweep_end_idle", 32'({a_valid, a_busy, a_done}), 32'd0);
    tick();
    chk("sweep_no_restart", 32'({a_valid, a_busy, a_done}), 32'd0);
`endif

    // return to manual, then abort a sweep at sel_out=5
    a_mode = 1'b0;
    a_sel = 4'd1;
    tick();
    chk("to_manual", 32'({a_outp, a_valid, a_busy, a_done}), 32'b1100);
    a_mode = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_pre_sel", 32'(a_sel_out), 32'(i));
    end
    a_mode = 1'b0;
    a_sel = 4'd2;
    tick();
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_manual", 32'({a_outp, a_sel_out, a_valid}), 32'b0_0010_1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'({a_busy, a_done}), 32'd0);
    end

    // dwell and width: NCH=4, WIDTH=8, DWELL=3
    b_mode = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("dwell_gap_valid", 32'(b_valid), 32'd0);
`ifdef MUX_SCAN_CONT_EN
    n_sw = 15;
`else
    n_sw = 12;
`endif
    for (int i = 0; i < n_sw; i++) begin
      tick();
      chk("dwell_outp", 32'(b_outp), 32'(bexp[(i / 3) % 4]));
      chk("dwell_sel_out", 32'(b_sel_out), 32'((i / 3) % 4));
      chk("dwell_done", 32'(b_done), 32'((i % 12) == 11));
      chk("dwell_valid", 32'(b_valid), 32'd1);
    end
`ifndef MUX_SCAN_CONT_EN
    tick();
    chk("dwell_end_idle", 32'({b_valid, b_busy}), 32'd0);
`endif
    b_mode = 1'b0;
    b_sel = 2'd3;
    tick();
    chk("b_manual", 32'({b_outp, b_valid}), 32'h1BB);

    // NCH=10: out-of-range manual selects and wrap at 9
    c_sel = 4'd9;
    tick();
    chk("c_sel9", 32'({c_outp, c_valid}), 32'b11);
    c_sel = 4'd10;
    tick();
    chk("c_sel10", 32'({c_outp, c_sel_out, c_valid}), 32'b0_1010_0);
    c_sel = 4'd12;
    tick();
    chk("c_sel12", 32'({c_outp, c_sel_out, c_valid}), 32'b0_1100_0);
    c_sel = 4'd15;
    tick();
    chk("c_sel15", 32'({c_outp, c_valid}), 32'b00);
    c_mode = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c_sweep_sel", 32'(c_sel_out), 32'(i));
      chk("c_sweep_done", 32'(c_done), 32'(i == 9));
    end
    tick();
`ifdef MUX_SCAN_CONT_EN
    chk("c_wrap", 32'({c_sel_out, c_valid, c_busy, c_done}), 32'b0000_110);
`else
    chk("c_end_idle", 32'({c_valid, c_busy, c_done}), 32'd0);
`endif
    c_mode = 1'b0;

    // asynchronous reset mid-cycle, with b mid-sweep
    a_mode = 1'b0;
    a_sel = 4'd3;
    b_mode = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_a", 32'({a_outp, a_sel_out, a_valid}), 32'b1_0011_1);
    chk("pre_reset_b_busy", 32'(b_busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_a", 32'({a_outp, a_sel_out, a_valid, a_busy, a_done}), 32'd0);
    chk("async_reset_b", 32'({b_outp, b_sel_out, b_valid, b_busy, b_done}), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("no_resume_b", 32'({b_valid, b_busy, b_done}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
